// File: rtl/gpu_pkg.sv
// Shared GPU core encodings: scheduler core_state, fetcher state and
// program-memory width defaults used by fetch, decode and scheduling.
package gpu_pkg;

  localparam int DEFAULT_PROGRAM_MEM_ADDR_BITS = 8;
  localparam int DEFAULT_PROGRAM_MEM_DATA_BITS = 16;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_e;

  typedef enum logic [2:0] {
    FETCH_IDLE     = 3'b000,
    FETCH_FETCHING = 3'b001,
    FETCH_FETCHED  = 3'b010,
    FETCH_LOOKUP   = 3'b011
  } fetcher_state_e;

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache, one instruction per line.
// Lookup is purely combinational; fill and flush land on the clock edge.
// LINES must be a power of two and at least 2.
module icache_dm #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int LINES     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [ADDR_BITS-1:0] lookup_addr,
  output logic                 lookup_hit,
  output logic [DATA_BITS-1:0] lookup_data,
  input  logic                 fill_en,
  input  logic [ADDR_BITS-1:0] fill_addr,
  input  logic [DATA_BITS-1:0] fill_data
);

  localparam int INDEX_BITS = $clog2(LINES);
  localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS;

  logic [LINES-1:0]                line_valid;
  logic [LINES-1:0][TAG_BITS-1:0]  line_tag;
  logic [LINES-1:0][DATA_BITS-1:0] line_data;

  logic [INDEX_BITS-1:0] lk_idx, fl_idx;
  logic [TAG_BITS-1:0]   lk_tag, fl_tag;

  assign lk_idx = lookup_addr[INDEX_BITS-1:0];
  assign lk_tag = lookup_addr[ADDR_BITS-1:INDEX_BITS];
  assign fl_idx = fill_addr[INDEX_BITS-1:0];
  assign fl_tag = fill_addr[ADDR_BITS-1:INDEX_BITS];

  assign lookup_hit  = line_valid[lk_idx] && (line_tag[lk_idx] == lk_tag);
  assign lookup_data = line_data[lk_idx];

  // Valid bits: flush beats a same-cycle fill so a racing fill stays invalid.
  always_ff @(posedge clk) begin
    if (reset)        line_valid <= '0;
    else if (flush)   line_valid <= '0;
    else if (fill_en) line_valid[fl_idx] <= 1'b1;
  end

  // Tag/data arrays carry no reset; a cleared valid bit masks stale contents.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      line_tag[fl_idx]  <= fl_tag;
      line_data[fl_idx] <= fill_data;
    end
  end

endmodule

// File: rtl/instr_fetcher.sv
// Per-core fetch stage: looks the latched PC up in the instruction cache,
// falls back to the program-memory valid/ready handshake on a miss, and
// holds the instruction for the decoder. Hit/miss counters saturate.
module instr_fetcher
  import gpu_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = DEFAULT_PROGRAM_MEM_ADDR_BITS,
  parameter int PROGRAM_MEM_DATA_BITS = DEFAULT_PROGRAM_MEM_DATA_BITS,
  parameter int CACHE_LINES           = 8,
  parameter int COUNTER_BITS          = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             cache_flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [COUNTER_BITS-1:0]          hit_count,
  output logic [COUNTER_BITS-1:0]          miss_count
);

  fetcher_state_e state, next_state;

  logic [PROGRAM_MEM_ADDR_BITS-1:0] fetch_addr;
  logic                             cache_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] cache_data;

  logic handshake;
  logic latch_pc, hit_take, miss_issue, fill_take;

  assign handshake     = mem_read_valid && mem_read_ready;
  assign fetcher_state = state;

  icache_dm #(
    .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS (PROGRAM_MEM_DATA_BITS),
    .LINES     (CACHE_LINES)
  ) u_icache (
    .clk         (clk),
    .reset       (reset),
    .flush       (cache_flush),
    .lookup_addr (fetch_addr),
    .lookup_hit  (cache_hit),
    .lookup_data (cache_data),
    .fill_en     (fill_take),
    .fill_addr   (fetch_addr),
    .fill_data   (mem_read_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH_IDLE;
    else       state <= next_state;
  end

  // Next state: once a lookup starts, core_state is ignored until FETCHED.
  always_comb begin
    next_state = state;
    unique case (state)
      FETCH_IDLE:     if (core_state == CORE_FETCH) next_state = FETCH_LOOKUP;
      FETCH_LOOKUP:   next_state = cache_hit ? FETCH_FETCHED : FETCH_FETCHING;
      FETCH_FETCHING: if (handshake) next_state = FETCH_FETCHED;
      FETCH_FETCHED:  if (core_state == CORE_DECODE) next_state = FETCH_IDLE;
      default:        next_state = FETCH_IDLE;
    endcase
  end

  // Per-state action strobes for the datapath below.
  always_comb begin
    latch_pc   = 1'b0;
    hit_take   = 1'b0;
    miss_issue = 1'b0;
    fill_take  = 1'b0;
    unique case (state)
      FETCH_IDLE:     latch_pc = (core_state == CORE_FETCH);
      FETCH_LOOKUP: begin
        hit_take   = cache_hit;
        miss_issue = !cache_hit;
      end
      FETCH_FETCHING: fill_take = handshake;
      default: ;
    endcase
  end

  // Fetch address is captured once so later PC changes do not disturb it.
  always_ff @(posedge clk) begin
    if (reset)         fetch_addr <= '0;
    else if (latch_pc) fetch_addr <= current_pc;
  end

  // Request, instruction and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
      hit_count        <= '0;
      miss_count       <= '0;
    end else begin
      if (hit_take) begin
        instruction <= cache_data;
        if (hit_count != '1) hit_count <= hit_count + COUNTER_BITS'(1);
      end
      if (miss_issue) begin
        mem_read_valid   <= 1'b1;
        mem_read_address <= fetch_addr;
        if (miss_count != '1) miss_count <= miss_count + COUNTER_BITS'(1);
      end
      if (fill_take) begin
        instruction    <= mem_read_data;
        mem_read_valid <= 1'b0;
      end
    end
  end

endmodule
